exc_code_gen: RTL and testbench

//   Request-side partner of the clock/mode controller: turns raw board buttons and CPU events into
//   a held 4-bit exception code, holds it until the controller's mode output shows acceptance, then

---
 rtl/exc_gen_pkg.sv | 47 ++++
 rtl/btn_debounce.sv | 44 ++++
 rtl/exc_code_gen.sv | 215 +++++++++++++++++++++
 tb/tb_exc_code_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_gen_pkg.sv
// Shared constants, FSM state type and the code-to-mode acceptance map for
// the exception code generator.
package exc_gen_pkg;

    localparam logic [3:0] EXC_NONE      = 4'd0;
    localparam logic [3:0] EXC_RST       = 4'd1;
    localparam logic [3:0] EXC_ERR       = 4'd2;
    localparam logic [3:0] EXC_CONT      = 4'd3;
    localparam logic [3:0] EXC_PAUSE     = 4'd4;
    localparam logic [3:0] EXC_UART      = 4'd5;
    localparam logic [3:0] EXC_UART_DONE = 4'd6;

    localparam logic [3:0] MODE_ERR   = 4'd2;
    localparam logic [3:0] MODE_PAUSE = 4'd4;
    localparam logic [3:0] MODE_RUN   = 4'd5;
    localparam logic [3:0] MODE_UART  = 4'd6;

    localparam int N_BTN      = 5;
    localparam int N_SLOT     = 7;
    localparam int SLOT_RST   = 0;
    localparam int SLOT_ERR   = 1;
    localparam int SLOT_PAUSE = 2;
    localparam int SLOT_CONT  = 3;
    localparam int SLOT_UART  = 4;
    localparam int SLOT_UDONE = 5;
    localparam int SLOT_ECALL = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    function automatic logic [3:0] expected_mode(input logic [3:0] code);
        case (code)
            EXC_RST:       expected_mode = MODE_RUN;
            EXC_ERR:       expected_mode = MODE_ERR;
            EXC_CONT:      expected_mode = MODE_RUN;
            EXC_PAUSE:     expected_mode = MODE_PAUSE;
            EXC_UART:      expected_mode = MODE_UART;
            EXC_UART_DONE: expected_mode = MODE_RUN;
            default:       expected_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter and a one-cycle pulse
// on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    // Level only follows the synchronised input after an unbroken run of differing samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_sync <= {r_sync[0], btn_i};
            r_rise <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_cnt   <= {CNT_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/exc_code_gen.sv
// Turns debounced buttons, UART-done and CPU ecalls into held exception codes for the
// mode controller. Optional sticky error lock is enabled by EXC_GEN_STICKY_ERR_EN.
module exc_code_gen
    import exc_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int ACK_TIMEOUT     = 64,
    parameter int CNT_W           = 18
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_BTN-1:0] btn_i,
    input  logic             ecall_valid_i,
    input  logic [3:0]       ecall_code_i,
    input  logic             uart_done_i,
    input  logic [3:0]       mode_i,
    output logic [3:0]       exc_code_o,
    output logic             set_cnt_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int              WAIT_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ACK_TIMEOUT - 1);

    logic [N_BTN-1:0]  w_rise;
    logic [N_SLOT-1:0] r_pend;
    logic [3:0]        r_ecall_code;
    logic              w_ecall_ok;
    logic [N_SLOT-1:0] w_set;
    logic [N_SLOT-1:0] w_elig;
    logic [N_SLOT-1:0] w_drop;
    logic [N_SLOT-1:0] w_grant_oh;
    logic [3:0]        w_grant_code;
    logic              w_grant_fire;
    logic              w_ack;

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_code, w_code_nxt;
    logic [3:0]        r_exc_code, w_exc_nxt;
    logic              r_set_cnt, w_set_cnt_nxt;
    logic              r_busy;
    logic              r_timeout, w_timeout_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .btn_i   (btn_i[g]),
            .rise_o  (w_rise[g])
        );
    end

    assign w_ecall_ok = ecall_valid_i && (ecall_code_i != 4'd0) && (ecall_code_i <= 4'd6);
    assign w_set      = {w_ecall_ok, uart_done_i, w_rise};

`ifdef EXC_GEN_STICKY_ERR_EN
    localparam logic [N_SLOT-1:0] LOCK_MASK = 7'b001_0001;
    logic r_err_lock, w_lock_nxt;

    assign w_elig = r_err_lock ? (r_pend & LOCK_MASK) : r_pend;
    assign w_drop = r_err_lock ? (r_pend & ~LOCK_MASK) : {N_SLOT{1'b0}};

    // Lock engages on an acknowledged error and is released by issuing rst or uart.
    always_comb begin
        w_lock_nxt = r_err_lock;
        if (w_grant_fire && ((w_grant_code == EXC_RST) || (w_grant_code == EXC_UART))) begin
            w_lock_nxt = 1'b0;
        end else if (w_ack && (r_code == EXC_ERR)) begin
            w_lock_nxt = 1'b1;
        end else begin
            w_lock_nxt = r_err_lock;
        end
    end

    // Error lock flag register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err_lock <= 1'b0;
        end else begin
            r_err_lock <= w_lock_nxt;
        end
    end
`else
    assign w_elig = r_pend;
    assign w_drop = {N_SLOT{1'b0}};
`endif

    // Fixed-priority arbiter: uart, rst, err, pause, continue, uart_done, ecall.
    always_comb begin
        w_grant_oh   = {N_SLOT{1'b0}};
        w_grant_code = EXC_NONE;
        if (w_elig[SLOT_UART]) begin
            w_grant_oh[SLOT_UART] = 1'b1;
            w_grant_code          = EXC_UART;
        end else if (w_elig[SLOT_RST]) begin
            w_grant_oh[SLOT_RST] = 1'b1;
            w_grant_code         = EXC_RST;
        end else if (w_elig[SLOT_ERR]) begin
            w_grant_oh[SLOT_ERR] = 1'b1;
            w_grant_code         = EXC_ERR;
        end else if (w_elig[SLOT_PAUSE]) begin
            w_grant_oh[SLOT_PAUSE] = 1'b1;
            w_grant_code           = EXC_PAUSE;
        end else if (w_elig[SLOT_CONT]) begin
            w_grant_oh[SLOT_CONT] = 1'b1;
            w_grant_code          = EXC_CONT;
        end else if (w_elig[SLOT_UDONE]) begin
            w_grant_oh[SLOT_UDONE] = 1'b1;
            w_grant_code           = EXC_UART_DONE;
        end else if (w_elig[SLOT_ECALL]) begin
            w_grant_oh[SLOT_ECALL] = 1'b1;
            w_grant_code           = r_ecall_code;
        end else begin
            w_grant_oh   = {N_SLOT{1'b0}};
            w_grant_code = EXC_NONE;
        end
    end

    // Pending slots: new requests are OR-ed in after clearing, so a same-cycle re-request survives.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pend       <= {N_SLOT{1'b0}};
            r_ecall_code <= EXC_NONE;
        end else begin
            r_pend <= (r_pend & ~((w_grant_fire ? w_grant_oh : {N_SLOT{1'b0}}) | w_drop)) | w_set;
            if (w_ecall_ok) begin
                r_ecall_code <= ecall_code_i;
            end else begin
                r_ecall_code <= r_ecall_code;
            end
        end
    end

    // FSM next state and next registered outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_exc_nxt     = r_exc_code;
        w_set_cnt_nxt = 1'b0;
        w_timeout_nxt = r_timeout;
        w_wait_nxt    = r_wait_cnt;
        w_grant_fire  = 1'b0;
        w_ack         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_grant_fire  = 1'b1;
                    w_state_nxt   = ST_ISSUE;
                    w_code_nxt    = w_grant_code;
                    w_exc_nxt     = w_grant_code;
                    w_set_cnt_nxt = (w_grant_code == EXC_RST);
                end else begin
                    w_exc_nxt = EXC_NONE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                w_wait_nxt  = {WAIT_W{1'b0}};
            end
            ST_WAIT: begin
                if (mode_i == expected_mode(r_code)) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ST_HOLDOFF;
                    w_exc_nxt   = EXC_NONE;
                end else if (r_wait_cnt == WAIT_MAX) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_HOLDOFF;
                    w_exc_nxt     = EXC_NONE;
                end else begin
                    w_wait_nxt = r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLDOFF: begin
                w_state_nxt = ST_IDLE;
                w_exc_nxt   = EXC_NONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_exc_nxt   = EXC_NONE;
            end
        endcase
    end

    // FSM state and output registers; busy reflects the state being entered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_code     <= EXC_NONE;
            r_exc_code <= EXC_NONE;
            r_set_cnt  <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_exc_code <= w_exc_nxt;
            r_set_cnt  <= w_set_cnt_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_timeout  <= w_timeout_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign exc_code_o = r_exc_code;
    assign set_cnt_o  = r_set_cnt;
    assign busy_o     = r_busy;
    assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_exc_code_gen.sv
// Scoreboard bench for exc_code_gen: stimulus pushes expected code episodes, a monitor
// measures each nonzero exc_code_o episode and compares. Honours EXC_GEN_STICKY_ERR_EN.
module tb_exc_code_gen;

    typedef struct {
        logic [3:0] code;
        int         len;
        int         sc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic       ecall_valid;
    logic [3:0] ecall_code;
    logic       uart_done;
    logic [3:0] man_mode;
    logic       resp_en;
    logic [3:0] mode_s;
    logic [3:0] exc_code_o;
    logic       set_cnt_o;
    logic       busy_o;
    logic       timeout_o;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic       in_ep = 1'b0;
    logic [3:0] ep_code;
    int         ep_len;
    int         ep_sc;

    exc_code_gen #(
        .DEBOUNCE_CYCLES (16),
        .ACK_TIMEOUT     (8),
        .CNT_W           (18)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .btn_i         (btn),
        .ecall_valid_i (ecall_valid),
        .ecall_code_i  (ecall_code),
        .uart_done_i   (uart_done),
        .mode_i        (mode_s),
        .exc_code_o    (exc_code_o),
        .set_cnt_o     (set_cnt_o),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    // Controller stand-in: answers each code with the mode it asks for.
    function automatic logic [3:0] resp_mode(input logic [3:0] c);
        case (c)
            4'd1:    resp_mode = 4'd5;
            4'd2:    resp_mode = 4'd2;
            4'd3:    resp_mode = 4'd5;
            4'd4:    resp_mode = 4'd4;
            4'd5:    resp_mode = 4'd6;
            4'd6:    resp_mode = 4'd5;
            default: resp_mode = 4'd5;
        endcase
    endfunction

    assign mode_s = resp_en ? resp_mode(exc_code_o) : man_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] c, input int len, input int sc);
        exp_t e;
        e.code = c; e.len = len; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic wait_code(input logic [3:0] c);
        int k;
        k = 0;
        while (exc_code_o != c && k < 200) begin
            tick(1);
            k++;
        end
        check("wait_code", int'(exc_code_o), int'(c));
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        tick(40);
        btn[b] = 1'b0;
        tick(40);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    // Episode monitor: measures each nonzero run of exc_code_o and scores it.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_ep = 1'b0;
        end else if (exc_code_o != 4'd0) begin
            if (!in_ep) begin
                in_ep   = 1'b1;
                ep_code = exc_code_o;
                ep_len  = 0;
                ep_sc   = 0;
            end else begin
                check("code_stable", int'(exc_code_o), int'(ep_code));
            end
            ep_len++;
            if (set_cnt_o) ep_sc++;
        end else if (in_ep) begin
            in_ep = 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected_episode_code", int'(ep_code), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("episode_code", int'(ep_code), int'(e.code));
                check("episode_len", ep_len, e.len);
                check("episode_set_cnt", ep_sc, e.sc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        btn         = 5'b0;
        ecall_valid = 1'b0;
        ecall_code  = 4'd0;
        uart_done   = 1'b0;
        man_mode    = 4'd5;
        resp_en     = 1'b1;
        tick(3);
        check("rst_exc_code", int'(exc_code_o), 0);
        check("rst_set_cnt", int'(set_cnt_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_timeout", int'(timeout_o), 0);
        rst_n = 1'b1;
        tick(3);

        // Async reset in the middle of WAIT, with a request queued behind it.
        resp_en = 1'b0; man_mode = 4'd2;
        ecall_valid = 1'b1; ecall_code = 4'd3;
        tick(1);
        ecall_valid = 1'b0;
        wait_code(4'd3);
        tick(3);
        ecall_valid = 1'b1; ecall_code = 4'd5;
        tick(1);
        ecall_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst_exc", int'(exc_code_o), 0);
        check("midwait_rst_busy", int'(busy_o), 0);
        check("midwait_rst_timeout", int'(timeout_o), 0);
        tick(2);
        rst_n = 1'b1;
        man_mode = 4'd5; resp_en = 1'b1;
        tick(30);
        check("after_rst_busy", int'(busy_o), 0);

        // Bouncing err button: only the final stable hold counts.
        push(4'd2, 2, 0);
        for (int i = 0; i < 50; i++) begin
            btn[1] = ~btn[1];
            tick(10);
        end
        press(1);
        apply_reset();

        // Handshake: controller switches to pause on the fifth WAIT cycle.
        resp_en = 1'b0; man_mode = 4'd5;
        push(4'd4, 6, 0);
        btn[2] = 1'b1;
        wait_code(4'd4);
        tick(5);
        man_mode = 4'd4;
        tick(1);
        check("holdoff_exc", int'(exc_code_o), 0);
        check("holdoff_busy", int'(busy_o), 1);
        tick(1);
        check("idle_busy", int'(busy_o), 0);
        btn[2] = 1'b0;
        tick(30);
        man_mode = 4'd5; resp_en = 1'b1;

        // Priority: uart beats rst when both arrive together.
        push(4'd5, 2, 0);
        push(4'd1, 2, 1);
        btn[0] = 1'b1; btn[4] = 1'b1;
        tick(40);
        btn[0] = 1'b0; btn[4] = 1'b0;
        tick(40);

        // Timeout: controller stuck in err mode.
        resp_en = 1'b0; man_mode = 4'd2;
        push(4'd3, 9, 0);
        ecall_valid = 1'b1; ecall_code = 4'd3;
        tick(1);
        ecall_valid = 1'b0;
        tick(25);
        check("timeout_set", int'(timeout_o), 1);
        man_mode = 4'd5; resp_en = 1'b1;
        tick(5);
        check("timeout_sticky", int'(timeout_o), 1);

        // Ecall overwrite and invalid code while busy with uart_done.
        resp_en = 1'b0; man_mode = 4'd2;
        push(4'd6, 4, 0);
        push(4'd6, 2, 0);
        uart_done = 1'b1;
        tick(1);
        uart_done = 1'b0;
        wait_code(4'd6);
        ecall_valid = 1'b1; ecall_code = 4'd4;
        tick(1);
        ecall_code = 4'd7;
        tick(1);
        ecall_code = 4'd6;
        tick(1);
        ecall_valid = 1'b0; ecall_code = 4'd0;
        resp_en = 1'b1;
        tick(20);
        check("timeout_still_sticky", int'(timeout_o), 1);

        // Error followed by pause, then rst.
        push(4'd2, 2, 0);
        press(1);
`ifdef EXC_GEN_STICKY_ERR_EN
        press(2);
        push(4'd1, 2, 1);
        press(0);
`else
        push(4'd4, 2, 0);
        press(2);
`endif
        tick(10);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_busy", int'(busy_o), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
